pipeline_hazard_ctrl: RTL and testbench

//  Sequencing controller for the RV32IM 5-stage pipeline datapath muxes.

---
 rtl/pipeline_ctrl_pkg.sv | 28 ++
 rtl/pipeline_hazard_ctrl_fwd_cmp.sv | 37 +++
 rtl/pipeline_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller:
// FSM state encodings, forwarding-mux select codes and a source-match helper.
`timescale 1ns/1ps
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MD_WAIT    = 2'd2
    } state_t;

    // Operand mux select codes; 2'b11 is never produced.
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // A source register depends on a writer when it is real, non-x0,
    // equal to the writer's rd, and the writer actually writes back.
    function automatic logic src_match(
        input logic       valid,
        input logic [4:0] rs,
        input logic [4:0] rd,
        input logic       regwrite
    );
        return valid && (rs != 5'd0) && (rs == rd) && regwrite;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_cmp.sv
// Per-source-operand comparator: picks the forwarding source for one rs
// (EX/MEM result beats MEM/WB result) and flags a load-use dependency.
`timescale 1ns/1ps
module hazard_fwd_cmp
    import pipeline_ctrl_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] rs,
    input  logic [4:0] ex_rd,
    input  logic       ex_regwrite,
    input  logic       ex_memread,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    output logic [1:0] fwd_sel,
    output logic       load_use
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = src_match(id_valid, rs, ex_rd, ex_regwrite);
    assign mem_hit = src_match(id_valid, rs, mem_rd, mem_regwrite);

    // Youngest producer wins: EX match shadows any MEM match.
    always_comb begin
        fwd_sel = FWD_REG;
        if (ex_hit) begin
            fwd_sel = FWD_EXMEM;
        end else if (mem_hit) begin
            fwd_sel = FWD_MEMWB;
        end
    end

    // A load in EX cannot forward yet; the consumer must wait one cycle.
    assign load_use = ex_hit && ex_memread;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: registered EX operand
// forwarding selects, PC mux select, and stall/bubble/flush controls for
// taken branches, load-use hazards and multi-cycle mul/div operations.
`timescale 1ns/1ps
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 34,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_md,
    input  logic [4:0] ex_rd,
    input  logic       ex_regwrite,
    input  logic       ex_memread,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic       branch_taken,
    input  logic       md_done,
    output logic [1:0] fwd_sel1,
    output logic [1:0] fwd_sel2,
    output logic       pc_sel,
    output logic       stall_pc,
    output logic       stall_ifid,
    output logic       stall_idex,
    output logic       bubble_idex,
    output logic       flush_ifid,
    output logic       md_busy,
    output logic       md_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             md_err_reg;
    logic             err_set;

    logic [4:0] rs_arr      [2];
    logic [1:0] sel_next    [2];
    logic [1:0] fwd_sel_reg [2];
    logic [1:0] load_use_vec;

    assign rs_arr[0] = id_rs1;
    assign rs_arr[1] = id_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            hazard_fwd_cmp u_cmp (
                .id_valid     (id_valid),
                .rs           (rs_arr[gi]),
                .ex_rd        (ex_rd),
                .ex_regwrite  (ex_regwrite),
                .ex_memread   (ex_memread),
                .mem_rd       (mem_rd),
                .mem_regwrite (mem_regwrite),
                .fwd_sel      (sel_next[gi]),
                .load_use     (load_use_vec[gi])
            );

            // Select follows the instruction into EX: cleared with a bubble,
            // frozen while ID/EX is held, otherwise loaded from ID.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    fwd_sel_reg[gi] <= FWD_REG;
                end else if (bubble_idex || flush_ifid) begin
                    fwd_sel_reg[gi] <= FWD_REG;
                end else if (!stall_idex) begin
                    fwd_sel_reg[gi] <= sel_next[gi];
                end
            end
        end
    endgenerate

    assign fwd_sel1 = fwd_sel_reg[0];
    assign fwd_sel2 = fwd_sel_reg[1];
    assign md_err   = md_err_reg;

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_RUN;
            cnt_reg    <= '0;
            md_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (err_set) begin
                md_err_reg <= 1'b1;
            end
        end
    end

    // Next-state and control outputs; branch beats load-use beats mul/div.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        err_set     = 1'b0;
        pc_sel      = 1'b0;
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        md_busy     = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (branch_taken) begin
                    pc_sel      = 1'b1;
                    flush_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                end else if (|load_use_vec) begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                    state_next  = ST_LOAD_STALL;
                end else if (id_md && id_valid) begin
                    state_next = ST_MD_WAIT;
                    cnt_next   = '0;
                end
            end
            ST_LOAD_STALL: begin
                // The load has moved to MEM; no re-detection this cycle.
                state_next = ST_RUN;
            end
            ST_MD_WAIT: begin
                if (md_done) begin
                    // Result ready: release the pipeline in this same cycle,
                    // so busy and the stalls both drop together.
                    state_next = ST_RUN;
                end else begin
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                    stall_idex = 1'b1;
                    md_busy    = 1'b1;
                    if (cnt_reg != CNT_MAX) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                    if (cnt_reg == CNT_LAST) begin
                        err_set    = 1'b1;
                        state_next = ST_RUN;
                    end
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: the driver applies one input vector per cycle and pushes
// the reference model's expected outputs; the monitor pops and compares.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_md, ex_regwrite, ex_memread, mem_regwrite;
    logic       branch_taken, md_done;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic [1:0] fwd_sel1, fwd_sel2;
    logic       pc_sel, stall_pc, stall_ifid, stall_idex, bubble_idex;
    logic       flush_ifid, md_busy, md_err;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    logic [11:0] exp_q[$];

    // Reference model state.
    logic [1:0] m_fwd1, m_fwd2;
    logic       m_err;
    bit         m_after_load;
    int         m_md_cnt;     // -1 when no mul/div is outstanding

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_md        (id_md),
        .ex_rd        (ex_rd),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .branch_taken (branch_taken),
        .md_done      (md_done),
        .fwd_sel1     (fwd_sel1),
        .fwd_sel2     (fwd_sel2),
        .pc_sel       (pc_sel),
        .stall_pc     (stall_pc),
        .stall_ifid   (stall_ifid),
        .stall_idex   (stall_idex),
        .bubble_idex  (bubble_idex),
        .flush_ifid   (flush_ifid),
        .md_busy      (md_busy),
        .md_err       (md_err)
    );

    function automatic logic [11:0] dut_out();
        return {fwd_sel1, fwd_sel2, pc_sel, stall_pc, stall_ifid, stall_idex,
                bubble_idex, flush_ifid, md_busy, md_err};
    endfunction

    // Which source an operand should come from, straight from the rules.
    function automatic logic [1:0] want_fwd(input logic [4:0] rs);
        if (id_valid && rs != 0 && ex_regwrite && rs == ex_rd) return 2'd1;
        if (id_valid && rs != 0 && mem_regwrite && rs == mem_rd) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit load_hazard();
        return ex_memread && (want_fwd(id_rs1) == 2'd1 || want_fwd(id_rs2) == 2'd1);
    endfunction

    task automatic model_reset();
        m_fwd1 = 0; m_fwd2 = 0; m_err = 0; m_after_load = 0; m_md_cnt = -1;
    endtask

    // Predict this cycle's outputs, queue them, then advance the model.
    task automatic model_step();
        bit pc = 0, spc = 0, sif = 0, sid = 0, bub = 0, fl = 0, busy = 0;
        bit adv = 0, clr = 0, err_next;
        err_next = m_err;
        if (m_md_cnt >= 0) begin
            if (md_done) begin
                m_md_cnt = -1;
                adv = 1;
            end else begin
                spc = 1; sif = 1; sid = 1; busy = 1;
                if (m_md_cnt == 33) begin
                    err_next = 1;
                    m_md_cnt = -1;
                end else begin
                    m_md_cnt++;
                end
            end
        end else if (m_after_load) begin
            m_after_load = 0;
            adv = 1;
        end else if (branch_taken) begin
            pc = 1; fl = 1; bub = 1; clr = 1;
        end else if (load_hazard()) begin
            spc = 1; sif = 1; bub = 1; clr = 1;
            m_after_load = 1;
        end else begin
            adv = 1;
            if (id_md && id_valid) m_md_cnt = 0;
        end
        exp_q.push_back({m_fwd1, m_fwd2, pc, spc, sif, sid, bub, fl, busy, m_err});
        if (clr) begin
            m_fwd1 = 0; m_fwd2 = 0;
        end else if (adv) begin
            m_fwd1 = want_fwd(id_rs1);
            m_fwd2 = want_fwd(id_rs2);
        end
        m_err = err_next;
    endtask

    task automatic cyc(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic md, input logic [4:0] erd, input logic ewe,
                       input logic emr, input logic [4:0] mrd, input logic mwe,
                       input logic br, input logic dn);
        @(posedge clk);
        #1;
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_md = md;
        ex_rd = erd; ex_regwrite = ewe; ex_memread = emr;
        mem_rd = mrd; mem_regwrite = mwe; branch_taken = br; md_done = dn;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic set_idle_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_md = 0; ex_rd = 0;
        ex_regwrite = 0; ex_memread = 0; mem_rd = 0; mem_regwrite = 0;
        branch_taken = 0; md_done = 0;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (dut_out() !== 12'h000) begin
            errors++;
            $display("FAIL %s outputs=%h expected=000", name, dut_out());
        end else begin
            $display("%s outputs=%h expected=000 ok", name, dut_out());
        end
    endtask

    // Monitor: every cycle the DUT presents a response on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                logic [11:0] e;
                logic [11:0] a;
                e = exp_q.pop_front();
                a = dut_out();
                checks++;
                txn++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL txn %0d outputs=%h expected=%h", txn, a, e);
                end else begin
                    $display("txn %0d outputs=%h ok", txn, a);
                end
            end
        end
    end

    initial begin
        set_idle_inputs();
        model_reset();
        reset = 1'b1;
        #3;
        check_all_zero("reset");
        #9 reset = 1'b0;

        // Forward from EX, then EX priority over MEM, then rs=x0.
        cyc(1, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 5, 0, 5, 1, 0, 5, 1, 0, 0);
        cyc(1, 0, 0, 0, 5, 1, 0, 5, 1, 0, 0);
        idle(1);
        // rd=x0 in both stages never forwards.
        cyc(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
        idle(1);

        // Load-use on rs1=7, then the load sits in MEM.
        cyc(1, 7, 0, 0, 7, 1, 1, 0, 0, 0, 0);
        cyc(1, 7, 0, 0, 0, 0, 0, 7, 1, 0, 0);
        idle(2);

        // Load-use plus taken branch: branch wins.
        cyc(1, 7, 0, 0, 7, 1, 1, 0, 0, 1, 0);
        idle(2);

        // Mul/div finishing after 10 stalled cycles.
        cyc(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(10);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);

        // Mul/div timeout, then error stays set.
        cyc(1, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(40);

        // Asynchronous reset in the middle of a mul/div wait.
        cyc(1, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(5);
        @(negedge clk);
        #2;
        set_idle_inputs();
        reset = 1'b1;
        #1;
        check_all_zero("reset_mid_md_wait");
        model_reset();
        #1 reset = 1'b0;
        idle(2);

        // Randomized traffic over a small register set to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 7) != 0,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                $urandom_range(0, 9) == 0,
                5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) == 0,
                5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 7) == 0);
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
